// File: rtl/segment_stepper.sv
// Segment FIFO reader: pops 4-byte motion records and plays each one out as a
// train of fixed-width step pulses with a direction level.
module segment_stepper #(
  parameter int WORD_SIZE    = 8,
  parameter int RECORD_WORDS = 4,
  parameter int PULSE_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [WORD_SIZE-1:0] fifo_data,
  output logic                 fifo_read_en,
  output logic                 step,
  output logic                 dir,
  output logic                 busy,
  output logic [7:0]           segment_count
);

  localparam logic [15:0] MIN_PERIOD = 16'(2 * PULSE_WIDTH);
  localparam logic [15:0] PW         = 16'(PULSE_WIDTH);
  localparam logic [1:0]  LAST_IDX   = 2'(RECORD_WORDS - 1);

  typedef enum logic [2:0] {IDLE, REQ, CAP, LOAD, RUN, NEXT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [WORD_SIZE-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
  logic [14:0]          steps_left_q, steps_left_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          eff_q, eff_d;
  logic                 step_q, step_d;
  logic                 dir_q, dir_d;
  logic [7:0]           seg_q, seg_d;

  // Pulses need a low phase at least as long as the high phase.
  function automatic logic [15:0] eff_period(input logic [15:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
      b3_q         <= '0;
      steps_left_q <= '0;
      cnt_q        <= '0;
      eff_q        <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      seg_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      b3_q         <= b3_d;
      steps_left_q <= steps_left_d;
      cnt_q        <= cnt_d;
      eff_q        <= eff_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      seg_q        <= seg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    b2_d         = b2_q;
    b3_d         = b3_q;
    steps_left_d = steps_left_q;
    cnt_d        = cnt_q;
    eff_d        = eff_q;
    dir_d        = dir_q;
    seg_d        = seg_q;
    fifo_read_en = 1'b0;
    // Registered: high on the cycles following RUN counts 0..PULSE_WIDTH-1.
    step_d       = (state_q == RUN) && (cnt_q < PW);

    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = REQ;
          idx_d   = '0;
        end
      end
      REQ: begin
        if (!fifo_empty) begin
          fifo_read_en = 1'b1;
          state_d      = CAP;
        end
      end
      CAP: begin
        unique case (idx_q)
          2'd0: b0_d = fifo_data;
          2'd1: begin
            b1_d  = fifo_data;
            dir_d = fifo_data[WORD_SIZE-1];
          end
          2'd2: b2_d = fifo_data;
          default: b3_d = fifo_data;
        endcase
        idx_d   = idx_q + 2'd1;
        state_d = (idx_q == LAST_IDX) ? LOAD : REQ;
      end
      LOAD: begin
        seg_d        = seg_q + 8'd1;
        steps_left_d = {b1_q[6:0], b0_q};
        cnt_d        = '0;
        eff_d        = eff_period({b3_q, b2_q});
        state_d      = ({b1_q[6:0], b0_q} == 15'd0) ? NEXT : RUN;
      end
      RUN: begin
        if (cnt_q == eff_q - 16'd1) begin
          cnt_d        = '0;
          steps_left_d = steps_left_q - 15'd1;
          if (steps_left_q == 15'd1) state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      NEXT: begin
        if (enable && !fifo_empty) begin
          state_d = REQ;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign step          = step_q;
  assign dir           = dir_q;
  assign busy          = (state_q != IDLE);
  assign segment_count = seg_q;

endmodule

// File: tb/tb_segment_stepper.sv
// Directed bench for segment_stepper: a small FIFO model feeds records and
// monitors time-stamp step edges, direction changes and pops.
module tb_segment_stepper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read_en;
  logic       step;
  logic       dir;
  logic       busy;
  logic [7:0] segment_count;

  int n_checks = 0;
  int n_fail   = 0;

  segment_stepper #(.WORD_SIZE(8), .RECORD_WORDS(4), .PULSE_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .step         (step),
    .dir          (dir),
    .busy         (busy),
    .segment_count(segment_count)
  );

  always #5 clk = ~clk;

  // FIFO model: tasks push, the DUT pops; data appears the cycle after the pop.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int underflow = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_read_en) begin
      if (wr_ptr == rd_ptr) underflow <= underflow + 1;
      else begin
        fifo_data <= mem[rd_ptr % 256];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   rise_cyc [0:63];
  logic rise_dir [0:63];
  int   high_len [0:63];
  int   rise_total = 0;
  int   fall_total = 0;
  int   readen_total = 0;
  int   busy_fall_cyc = 0;
  int   dir_chg_cyc = 0;
  int   step_viol = 0;
  logic prev_step = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_dir  = 1'b0;

  always @(negedge clk) begin
    prev_step <= step;
    prev_busy <= busy;
    prev_dir  <= dir;
    if (step && !prev_step) begin
      rise_cyc[rise_total % 64] <= cyc;
      rise_dir[rise_total % 64] <= dir;
      rise_total <= rise_total + 1;
    end
    if (!step && prev_step) begin
      high_len[fall_total % 64] <= cyc - rise_cyc[(rise_total - 1) % 64];
      fall_total <= fall_total + 1;
    end
    if (fifo_read_en) readen_total <= readen_total + 1;
    if (!busy && prev_busy) busy_fall_cyc <= cyc;
    if (dir != prev_dir) dir_chg_cyc <= cyc;
    if (step && !busy) step_viol <= step_viol + 1;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 256] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_rec(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    push(a); push(b); push(c); push(d);
  endtask

  task automatic wait_done(output bit ok);
    int n;
    ok = 1'b1;
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    if (!busy) ok = 1'b0;
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    if (busy) ok = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({step, dir, fifo_read_en, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000", {step, dir, fifo_read_en, busy});
    end
    n_checks++;
    if (segment_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_segcount: got %0d want 0", segment_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int rb = rise_total, fb = fall_total, eb = readen_total;
    bit ok;
    enable = 1'b1;
    push_rec(8'h03, 8'h00, 8'h28, 8'h00);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: got %0b want 1", ok); end
    n_checks++;
    if (rise_total - rb !== 3) begin
      n_fail++; $display("FAIL basic_pulses: got %0d want 3", rise_total - rb);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (high_len[(fb + i) % 64] !== 16) begin
        n_fail++; $display("FAIL basic_high%0d: got %0d want 16", i, high_len[(fb + i) % 64]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (rise_cyc[(rb + i) % 64] - rise_cyc[(rb + i - 1) % 64] !== 40) begin
        n_fail++;
        $display("FAIL basic_spacing%0d: got %0d want 40", i,
                 rise_cyc[(rb + i) % 64] - rise_cyc[(rb + i - 1) % 64]);
      end
    end
    n_checks++;
    if (dir !== 1'b0) begin n_fail++; $display("FAIL basic_dir: got %b want 0", dir); end
    n_checks++;
    if (segment_count !== 8'd1) begin
      n_fail++; $display("FAIL basic_segcount: got %0d want 1", segment_count);
    end
    n_checks++;
    if (readen_total - eb !== 4) begin
      n_fail++; $display("FAIL basic_pops: got %0d want 4", readen_total - eb);
    end
    n_checks++;
    if (busy_fall_cyc - rise_cyc[(rb + 2) % 64] !== 40) begin
      n_fail++;
      $display("FAIL basic_busy_fall: got %0d want 40", busy_fall_cyc - rise_cyc[(rb + 2) % 64]);
    end
  endtask

  task automatic test_dir();
    int rb = rise_total;
    bit ok;
    push_rec(8'h02, 8'h80, 8'h40, 8'h00);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL dir_timeout: got %0b want 1", ok); end
    n_checks++;
    if (rise_total - rb !== 2) begin
      n_fail++; $display("FAIL dir_pulses: got %0d want 2", rise_total - rb);
    end
    n_checks++;
    if (rise_dir[rb % 64] !== 1'b1) begin
      n_fail++; $display("FAIL dir_level: got %b want 1", rise_dir[rb % 64]);
    end
    n_checks++;
    if (rise_cyc[rb % 64] - dir_chg_cyc < 4) begin
      n_fail++; $display("FAIL dir_lead: got %0d want >=4", rise_cyc[rb % 64] - dir_chg_cyc);
    end
    n_checks++;
    if (rise_cyc[(rb + 1) % 64] - rise_cyc[rb % 64] !== 64) begin
      n_fail++;
      $display("FAIL dir_spacing: got %0d want 64", rise_cyc[(rb + 1) % 64] - rise_cyc[rb % 64]);
    end
    n_checks++;
    if (segment_count !== 8'd2) begin
      n_fail++; $display("FAIL dir_segcount: got %0d want 2", segment_count);
    end
  endtask

  task automatic test_min_period();
    int rb = rise_total, fb = fall_total;
    bit ok;
    push_rec(8'h01, 8'h00, 8'h05, 8'h00);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL minp_timeout: got %0b want 1", ok); end
    n_checks++;
    if (rise_total - rb !== 1) begin
      n_fail++; $display("FAIL minp_pulses: got %0d want 1", rise_total - rb);
    end
    n_checks++;
    if (high_len[fb % 64] !== 16) begin
      n_fail++; $display("FAIL minp_high: got %0d want 16", high_len[fb % 64]);
    end
    n_checks++;
    if (busy_fall_cyc - rise_cyc[rb % 64] !== 32) begin
      n_fail++; $display("FAIL minp_period: got %0d want 32", busy_fall_cyc - rise_cyc[rb % 64]);
    end
    n_checks++;
    if (dir !== 1'b0) begin n_fail++; $display("FAIL minp_dir: got %b want 0", dir); end
  endtask

  task automatic test_zero_steps();
    int rb = rise_total, eb = readen_total;
    bit ok;
    push_rec(8'h00, 8'h00, 8'h10, 8'h00);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_timeout: got %0b want 1", ok); end
    n_checks++;
    if (rise_total - rb !== 0) begin
      n_fail++; $display("FAIL zero_pulses: got %0d want 0", rise_total - rb);
    end
    n_checks++;
    if (readen_total - eb !== 4) begin
      n_fail++; $display("FAIL zero_pops: got %0d want 4", readen_total - eb);
    end
    n_checks++;
    if (segment_count !== 8'd4) begin
      n_fail++; $display("FAIL zero_segcount: got %0d want 4", segment_count);
    end
  endtask

  task automatic test_partial();
    int rb = rise_total, eb = readen_total;
    bit ok;
    push(8'h02);
    push(8'h00);
    repeat (100) @(negedge clk);
    n_checks++;
    if (readen_total - eb !== 2) begin
      n_fail++; $display("FAIL partial_pops: got %0d want 2", readen_total - eb);
    end
    n_checks++;
    if (rise_total - rb !== 0 || step !== 1'b0) begin
      n_fail++; $display("FAIL partial_step: got %0d rises want 0", rise_total - rb);
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL partial_busy: got %b want 1", busy); end
    push(8'h22);
    push(8'h00);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL partial_timeout: got %0b want 1", ok); end
    n_checks++;
    if (rise_total - rb !== 2) begin
      n_fail++; $display("FAIL partial_pulses: got %0d want 2", rise_total - rb);
    end
    n_checks++;
    if (rise_cyc[(rb + 1) % 64] - rise_cyc[rb % 64] !== 34) begin
      n_fail++;
      $display("FAIL partial_spacing: got %0d want 34", rise_cyc[(rb + 1) % 64] - rise_cyc[rb % 64]);
    end
    n_checks++;
    if (readen_total - eb !== 4 || segment_count !== 8'd5) begin
      n_fail++;
      $display("FAIL partial_totals: got pops=%0d seg=%0d want pops=4 seg=5",
               readen_total - eb, segment_count);
    end
  endtask

  task automatic test_back_to_back();
    int rb;
    bit ok;
    do_reset();
    rb = rise_total;
    push_rec(8'h01, 8'h00, 8'h24, 8'h00);
    push_rec(8'h02, 8'h80, 8'h20, 8'h00);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got %0b want 1", ok); end
    n_checks++;
    if (segment_count !== 8'd2) begin
      n_fail++; $display("FAIL b2b_segcount: got %0d want 2", segment_count);
    end
    n_checks++;
    if (rise_total - rb !== 3) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d want 3", rise_total - rb);
    end
    n_checks++;
    if (rise_dir[rb % 64] !== 1'b0 || rise_dir[(rb + 1) % 64] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_order: got dir %b,%b want 0,1", rise_dir[rb % 64], rise_dir[(rb + 1) % 64]);
    end
    n_checks++;
    if (rise_cyc[(rb + 1) % 64] - rise_cyc[rb % 64] < 46) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d want >=46", rise_cyc[(rb + 1) % 64] - rise_cyc[rb % 64]);
    end
  endtask

  task automatic test_reset_mid_run();
    int rb, n;
    enable = 1'b0;
    do_reset();
    rb = rise_total;
    push_rec(8'h04, 8'h80, 8'h30, 8'h00);
    push_rec(8'h01, 8'h00, 8'h30, 8'h00);
    enable = 1'b1;
    n = 0;
    while (rise_total == rb && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (rise_total == rb) begin n_fail++; $display("FAIL rst_run_start: got 0 rises want 1"); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({step, busy, fifo_read_en, dir} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_run_outputs: got %b want 0000", {step, busy, fifo_read_en, dir});
    end
    n_checks++;
    if (segment_count !== 8'd0) begin
      n_fail++; $display("FAIL rst_run_segcount: got %0d want 0", segment_count);
    end
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || step !== 1'b0) begin
      n_fail++; $display("FAIL rst_run_idle: got busy=%b step=%b want 0,0", busy, step);
    end
  endtask

  task automatic test_invariants();
    n_checks++;
    if (underflow !== 0) begin n_fail++; $display("FAIL underflow: got %0d want 0", underflow); end
    n_checks++;
    if (step_viol !== 0) begin
      n_fail++; $display("FAIL step_outside_run: got %0d want 0", step_viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dir();
    test_min_period();
    test_zero_steps();
    test_partial();
    test_back_to_back();
    test_reset_mid_run();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/segment_stepper.md
Name: segment_stepper

Overview:
- Reader side of the segment FIFO: the SPI secondary writes 4-byte motion records into the FIFO, and this block pops them and executes them.
- Each record becomes a train of fixed-width step pulses plus a direction level.
- Sits between the FIFO read port and the motor driver pins; the FIFO slot count reported to the host drops as this block consumes records.

Parameters:
- WORD_SIZE, 8, FIFO word width in bits; must be 8.
- RECORD_WORDS, 4, words per segment record; must be 4.
- PULSE_WIDTH, 16, step high time in clk cycles; must be ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when high, the block may fetch new records.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  WORD_SIZE  FIFO data_out, valid the cycle after fifo_read_en.
- fifo_read_en  output  1  single-cycle pop request to the FIFO.
- step  output  1  step pulse.
- dir  output  1  direction level.
- busy  output  1  high in every state except IDLE.
- segment_count  output  8  records consumed; wraps 255→0.

Behaviour:
- Interface (decided): one clock, clk; reset is asynchronous and active-high.
- Reset values: step=0, dir=0, fifo_read_en=0, busy=0, segment_count=0, state=IDLE, all counters 0.
- Record format, bytes in pop order:
  - b0 = steps[7:0]
  - b1 = {dir, steps[14:8]}
  - b2 = period[7:0]
  - b3 = period[15:8]
- steps is 15-bit unsigned. period is clk cycles between step rising edges.
- Effective period = max(period, 2*PULSE_WIDTH), computed with 16-bit compare.
- State IDLE:
  - If enable && !fifo_empty → REQ, word index=0.
- State REQ:
  - Drive fifo_read_en=1 for exactly one cycle, only if !fifo_empty, then go to CAP.
  - If fifo_empty, stay in REQ with fifo_read_en=0. A partial record waits indefinitely; enable is not rechecked mid-record.
- State CAP:
  - Latch fifo_data into byte[index], index++.
  - If index was 3 → LOAD; else → REQ.
  - Minimum 8 cycles per record fetch.
- dir timing: dir updates in the CAP cycle that captures b1, so dir leads the first step edge by ≥4 cycles. dir holds until the next b1 capture.
- State LOAD:
  - Increment segment_count.
  - Load steps_left=steps and period counter=0.
  - If steps==0 → NEXT; else → RUN.
- State RUN:
  - Period counter counts 0..eff_period-1.
  - step=1 while counter<PULSE_WIDTH (registered output, asserted the cycle after entering RUN).
  - At counter==eff_period-1: steps_left--, counter=0.
  - If steps_left reaches 0 → NEXT.
- State NEXT:
  - If enable && !fifo_empty → REQ; else → IDLE.
  - Back-to-back gap between the last pulse period end and the next record's first pulse is ≥10 cycles.
- enable deassertion never truncates a record fetch or a segment in progress; it only blocks the next fetch.
- step is never high outside RUN.
- Asynchronous reset in any state returns to the reset values immediately. A partially fetched record is lost; the FIFO is not rewound.
- fifo_read_en is never asserted when fifo_empty=1. No underflow is possible.

Test Plan:
- PULSE_WIDTH=16; record {0x03,0x00,0x28,0x00} → 3 step pulses, each 16 cycles high, rising edges 40 cycles apart; dir=0; segment_count=1; busy falls after the third period.
- Record {0x02,0x80,0x40,0x00} → dir=1 at least 4 cycles before the first step rise; 2 pulses 64 cycles apart.
- Record with period=5 → effective period 32; 1 step → 16 high, 16 low.
- Record with steps=0 → no step pulse; segment_count increments; exactly 4 fifo_read_en pulses.
- Push 2 bytes, hold FIFO empty for 100 cycles → exactly 2 fifo_read_en pulses, step stays 0; push remaining bytes → segment executes normally.
- Two queued records, enable held high → both execute in order, segment_count=2. Repeat with reset asserted mid-RUN of the first → step=0, busy=0, segment_count=0 immediately.
